// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: FSM encoding, PC step and alignment check.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } pc_state_t;

    localparam int PC_STEP = 4;

    function automatic logic pc_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/clear; top and empty are combinational from state.
// Latency: updates visible the cycle after the request. No backpressure: push when full overwrites oldest.
// Pop-then-push in one cycle replaces the top entry.
module pc_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            push,
    input  logic            pop,
    input  logic            clr,
    input  logic [XLEN-1:0] push_dat,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   ptr;
    logic [AW:0]     count;
    logic            do_pop;
    logic [AW-1:0]   wr_idx;

    assign empty  = (count == '0);
    assign top    = mem[ptr - AW'(1)];
    assign do_pop = pop && !empty;
    // A simultaneous pop+push lands on the slot just vacated by the pop.
    assign wr_idx = do_pop ? (ptr - AW'(1)) : ptr;

    always_ff @(posedge Clk) begin
        if (push && !clr) begin
            mem[wr_idx] <= push_dat;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (clr) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && !do_pop) begin
            ptr   <= ptr + AW'(1);
            count <= (count == FULL) ? count : count + (AW+1)'(1);
        end else if (do_pop && !push) begin
            ptr   <= ptr - AW'(1);
            count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with trap > EX > ID redirect priority; optional RAS under PC_RAS_EN.
// Latency: 1 cycle from sampled redirect/advance to pc. Backpressure: holds pc while !fetch_ready or Stall.
// Misaligned redirect targets freeze fetch in FAULT until an aligned trap.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            ex_redirect,
    input  logic [XLEN-1:0] ex_target,
    input  logic            id_redirect,
    input  logic [XLEN-1:0] id_target,
    input  logic            id_call,
    input  logic            id_return,
    input  logic [XLEN-1:0] id_link,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr
);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc_nxt, fault_addr_nxt, tgt, ras_top;
    logic            fault_nxt, tgt_vld, id_sel, ras_empty;
    logic            ras_push, ras_pop, ras_clr;

    assign fetch_valid = (state == ST_RUN);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        fault_nxt      = fault;
        fault_addr_nxt = fault_addr;
        tgt            = '0;
        tgt_vld        = 1'b0;
        id_sel         = 1'b0;
        ras_push       = 1'b0;
        ras_pop        = 1'b0;
        ras_clr        = 1'b0;

        unique case (state)
            ST_BOOT: begin
                state_nxt = ST_RUN;
                if (trap_valid) begin
                    tgt_vld = 1'b1;
                    tgt     = trap_target;
                end
            end
            ST_RUN: begin
                if (trap_valid) begin
                    tgt_vld = 1'b1;
                    tgt     = trap_target;
                end else if (ex_redirect) begin
                    tgt_vld = 1'b1;
                    tgt     = ex_target;
                end else if (id_redirect) begin
                    tgt_vld = 1'b1;
                    id_sel  = 1'b1;
                    tgt     = (id_return && !ras_empty) ? ras_top : id_target;
                end else if (fetch_ready && !Stall) begin
                    pc_nxt = pc + XLEN'(PC_STEP);
                end
            end
            ST_FAULT: begin
                if (trap_valid) begin
                    tgt_vld = 1'b1;
                    tgt     = trap_target;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase

        // A misaligned target never reaches pc or the stack; it is parked in fault_addr.
        if (tgt_vld) begin
            if (pc_aligned(tgt[1:0])) begin
                pc_nxt    = tgt;
                state_nxt = ST_RUN;
                fault_nxt = 1'b0;
                ras_clr   = trap_valid;
                ras_push  = id_sel && id_call;
                ras_pop   = id_sel && id_return;
            end else begin
                fault_nxt      = 1'b1;
                fault_addr_nxt = tgt;
                state_nxt      = ST_FAULT;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_BOOT;
            pc         <= RESET_VECTOR;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            fault      <= fault_nxt;
            fault_addr <= fault_addr_nxt;
        end
    end

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .clr      (ras_clr),
        .push_dat (id_link),
        .top      (ras_top),
        .empty    (ras_empty)
    );
`else
    // Without a stack every return falls through to id_target.
    logic unused_ras;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ^{ras_push, ras_pop, ras_clr, id_link, (RAS_DEPTH > 1)};
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: inputs driven and outputs sampled on the falling edge.
module tb_pc_gen;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall, fetch_ready, fetch_valid;
    logic [31:0] pc;
    logic        trap_valid, ex_redirect, id_redirect, id_call, id_return, fault;
    logic [31:0] trap_target, ex_target, id_target, id_link, fault_addr;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .RAS_DEPTH    (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (Stall),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .pc          (pc),
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .id_redirect (id_redirect),
        .id_target   (id_target),
        .id_call     (id_call),
        .id_return   (id_return),
        .id_link     (id_link),
        .fault       (fault),
        .fault_addr  (fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_redir();
        trap_valid  = 1'b0; trap_target = '0;
        ex_redirect = 1'b0; ex_target   = '0;
        id_redirect = 1'b0; id_target   = '0;
        id_call     = 1'b0; id_return   = 1'b0; id_link = '0;
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; fetch_ready = 1'b1;
        clr_redir();
        cyc(); cyc();
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_faddr", fault_addr, 32'h0);

        // Boot, then sequential fetch
        Reset = 1'b0;
        cyc(); chk("boot_pc", pc, 32'h0); chk("run_fv", {31'b0, fetch_valid}, 32'd1);
        cyc(); chk("seq4", pc, 32'h4);
        cyc(); chk("seq8", pc, 32'h8);
        cyc(); chk("seqc", pc, 32'hc);
        cyc(); chk("seq10", pc, 32'h10);

        // Stall holds; redirect overrides stall
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("stall_hold", pc, 32'h10);
        end
        id_redirect = 1'b1; id_target = 32'h80;
        cyc(); chk("id_in_stall", pc, 32'h80);
        Stall = 1'b0;

        // Priority, with fetch_ready low to show redirects ignore it
        fetch_ready = 1'b0;
        trap_valid = 1'b1; trap_target = 32'h100;
        ex_redirect = 1'b1; ex_target = 32'h200;
        id_target = 32'h300;
        cyc(); chk("prio_trap", pc, 32'h100);
        trap_valid = 1'b0;
        cyc(); chk("prio_ex", pc, 32'h200);
        clr_redir();
        cyc(); chk("hold_nordy", pc, 32'h200);

        // Return with empty/absent stack goes to id_target
        id_redirect = 1'b1; id_return = 1'b1; id_target = 32'h400;
        cyc(); chk("ret_fallback", pc, 32'h400);
        clr_redir(); fetch_ready = 1'b1;

        // Misaligned EX target -> FAULT
        ex_redirect = 1'b1; ex_target = 32'h202;
        cyc();
        chk("flt_set", {31'b0, fault}, 32'd1);
        chk("flt_addr", fault_addr, 32'h202);
        chk("flt_pc", pc, 32'h400);
        chk("flt_fv", {31'b0, fetch_valid}, 32'd0);
        ex_target = 32'h600; id_redirect = 1'b1; id_target = 32'h500;
        cyc(); chk("flt_ignore", pc, 32'h400); chk("flt_stay", {31'b0, fault}, 32'd1);
        clr_redir();
        trap_valid = 1'b1; trap_target = 32'h41;
        cyc(); chk("flt_badtrap", fault_addr, 32'h41); chk("flt_badtrap_pc", pc, 32'h400);
        trap_target = 32'h40;
        cyc();
        chk("flt_clr", {31'b0, fault}, 32'd0);
        chk("flt_trap_pc", pc, 32'h40);
        chk("flt_rec_fv", {31'b0, fetch_valid}, 32'd1);
        clr_redir();
        cyc(); chk("post_flt_seq", pc, 32'h44);

`ifdef PC_RAS_EN
        // Five calls into a 4-deep stack, then a wrong-path call under an EX redirect
        for (int k = 1; k <= 5; k++) begin
            id_redirect = 1'b1; id_call = 1'b1; id_target = 32'h1000; id_link = 32'h10 * k;
            cyc(); chk("call_pc", pc, 32'h1000);
        end
        ex_redirect = 1'b1; ex_target = 32'h2000; id_link = 32'h990;
        cyc(); chk("ex_call_pc", pc, 32'h2000);
        clr_redir();
        begin
            logic [31:0] exp_ret [5];
            exp_ret[0] = 32'h50; exp_ret[1] = 32'h40; exp_ret[2] = 32'h30;
            exp_ret[3] = 32'h20; exp_ret[4] = 32'h3000;
            for (int k = 0; k < 5; k++) begin
                id_redirect = 1'b1; id_return = 1'b1; id_target = 32'h3000;
                cyc(); chk("ras_ret", pc, exp_ret[k]);
            end
        end
        clr_redir();
`endif

        // Wrap at top of address space
        id_redirect = 1'b1; id_target = 32'hFFFF_FFFC;
        cyc(); chk("top_pc", pc, 32'hFFFF_FFFC);
        clr_redir();
        cyc(); chk("wrap0", pc, 32'h0);
        cyc(); chk("wrap4", pc, 32'h4);

        // Async reset while faulted
        ex_redirect = 1'b1; ex_target = 32'h6;
        cyc(); chk("flt2_set", {31'b0, fault}, 32'd1);
        clr_redir();
        #2 Reset = 1'b1;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_fault", {31'b0, fault}, 32'd0);
        chk("arst_faddr", fault_addr, 32'h0);
        chk("arst_fv", {31'b0, fetch_valid}, 32'd0);
        cyc(); Reset = 1'b0;
        cyc(); chk("rerun_pc", pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
